ising_run_ctrl: RTL and testbench

//   Host-facing sequencer for an N x N coupled_cell oscillator array. Forwards weight writes
//   to the array's write bus, then runs one anneal: hold oscillators in reset, release,

---
 rtl/ising_run_ctrl_pkg.sv | 24 ++
 rtl/ising_run_ctrl_phase_sync.sv | 25 ++
 rtl/ising_run_ctrl.sv | 155 +++++++++++++++
 tb/tb_ising_run_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/ising_run_ctrl_pkg.sv
// Shared FSM states, CTRL bit positions and register map for the Ising run sequencer.
package ising_run_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOLD,
    S_RUN,
    S_SAMPLE,
    S_DONE
  } state_e;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_CLEAR = 1;
  localparam int unsigned CTRL_ABORT = 2;

  localparam logic [15:0] ADDR_CTRL  = 16'h0000;
  localparam logic [15:0] ADDR_LEN   = 16'h0004;
  localparam logic [15:0] ADDR_WBASE = 16'h1000;

  function automatic logic [31:0] clamp_w(input logic [31:0] v, input logic [31:0] maxv);
    return (v > maxv) ? maxv : v;
  endfunction

endpackage

// File: rtl/ising_run_ctrl_phase_sync.sv
// N-bit flop-chain synchroniser for the asynchronous oscillator phases.
module phase_sync #(
  parameter int unsigned N           = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_sync [SYNC_STAGES];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/ising_run_ctrl.sv
// Host-facing sequencer: forwards clamped weight writes and runs one timed anneal.
module ising_run_ctrl
  import ising_run_ctrl_pkg::*;
#(
  parameter int unsigned N           = 8,
  parameter int unsigned NUM_WEIGHTS = 15,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEF_LEN     = 1000,
  localparam int unsigned AW         = (N*N > 1) ? $clog2(N*N) : 1
) (
  input  logic          clk,
  input  logic          axi_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [15:0]   cmd_addr,
  input  logic [31:0]   cmd_data,
  output logic          arr_wready,
  output logic [AW-1:0] arr_wr_addr,
  output logic [31:0]   arr_wdata,
  output logic          ising_rstn,
  input  logic [N-1:0]  phase_in,
  output logic [N-1:0]  spin_out,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;

  state_e           r_state;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic [HW-1:0]    r_hold;
  logic             r_wready, r_rstn, r_busy, r_done, r_err;
  logic [AW-1:0]    r_waddr;
  logic [31:0]      r_wdata;
  logic [N-1:0]     r_spin;
  logic [N-1:0]     w_sync;
  logic [31:0]      w_off;
  logic             w_is_ctrl, w_is_len, w_is_wt;
  logic             w_start, w_clear, w_abort;
  logic [AW-1:0]    w_k;

  phase_sync #(.N(N), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk (clk),
    .i_rst (axi_rst),
    .i_d   (phase_in),
    .o_q   (w_sync)
  );

  // An address below the weight base wraps to a huge offset and fails the range check.
  assign w_off     = {16'h0000, cmd_addr} - {16'h0000, ADDR_WBASE};
  assign w_is_wt   = (w_off[1:0] == 2'b00) && (w_off[31:2] < 30'(N*N));
  assign w_k       = w_off[AW+1:2];
  assign w_is_ctrl = (cmd_addr == ADDR_CTRL);
  assign w_is_len  = (cmd_addr == ADDR_LEN);
  assign w_start   = cmd_valid && w_is_ctrl && cmd_data[CTRL_START];
  assign w_clear   = cmd_valid && w_is_ctrl && cmd_data[CTRL_CLEAR];
  assign w_abort   = cmd_valid && w_is_ctrl && cmd_data[CTRL_ABORT];

  always_ff @(posedge clk or posedge axi_rst) begin
    if (axi_rst) begin
      r_state  <= S_IDLE;
      r_len    <= CNT_W'(DEF_LEN);
      r_cnt    <= '0;
      r_hold   <= '0;
      r_wready <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_rstn   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_spin   <= '0;
    end else begin
      r_wready <= 1'b0;
      if (cmd_valid && w_is_wt) begin
        if (r_busy) begin
          r_err <= 1'b1;
        end else begin
          r_wready <= 1'b1;
          r_waddr  <= w_k;
          r_wdata  <= clamp_w(cmd_data, 32'(NUM_WEIGHTS - 1));
        end
      end else if (cmd_valid && w_is_len) begin
        if (r_busy) r_err <= 1'b1;
        else        r_len <= CNT_W'(cmd_data);
      end

      // Abort outranks clear, so an abort during a run leaves err alone.
      if (w_abort ? !r_busy : w_clear) r_err <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_start && !w_abort && !w_clear) begin
            r_state <= S_HOLD;
            r_hold  <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_HOLD, S_RUN, S_SAMPLE: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_rstn  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else if (r_state == S_HOLD) begin
            if (r_hold == HW'(RST_CYCLES - 1)) begin
              r_state <= S_RUN;
              r_rstn  <= 1'b1;
              r_cnt   <= (r_len == '0) ? CNT_W'(1) : r_len;
            end else begin
              r_hold <= r_hold + 1'b1;
            end
          end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) r_state <= S_SAMPLE;
          end else begin
            r_spin  <= w_sync;
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          if (w_abort || w_clear) begin
            r_state <= S_IDLE;
            r_rstn  <= 1'b0;
            r_done  <= 1'b0;
          end else if (w_start) begin
            r_state <= S_HOLD;
            r_hold  <= '0;
            r_rstn  <= 1'b0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = 1'b1;
  assign arr_wready  = r_wready;
  assign arr_wr_addr = r_waddr;
  assign arr_wdata   = r_wdata;
  assign ising_rstn  = r_rstn;
  assign spin_out    = r_spin;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_ising_run_ctrl.sv
// Directed bench for ising_run_ctrl: weight forwarding, anneal timing, abort/clear and reset.
module tb_ising_run_ctrl;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = 6;

  logic          clk, axi_rst, cmd_valid, cmd_ready;
  logic [15:0]   cmd_addr;
  logic [31:0]   cmd_data;
  logic          arr_wready, ising_rstn, busy, done, err;
  logic [AW-1:0] arr_wr_addr;
  logic [31:0]   arr_wdata;
  logic [N-1:0]  phase_in, spin_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;

  ising_run_ctrl #(
    .N(8), .NUM_WEIGHTS(15), .CNT_W(32), .RST_CYCLES(4), .SYNC_STAGES(2), .DEF_LEN(1000)
  ) dut (
    .clk(clk), .axi_rst(axi_rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .arr_wready(arr_wready),
    .arr_wr_addr(arr_wr_addr), .arr_wdata(arr_wdata), .ising_rstn(ising_rstn),
    .phase_in(phase_in), .spin_out(spin_out), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge (cycle t+1).
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
  endtask

  // Counts cycles from t+1 until done rises, bounded.
  task automatic wait_done(output int c);
    c = 1;
    while (!done && c < 2000) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    axi_rst   = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    phase_in  = 8'hA5;
    @(negedge clk);
    chk("rst_rstn", 32'(ising_rstn), 0);
    chk("rst_wready", 32'(arr_wready), 0);
    chk("rst_waddr", 32'(arr_wr_addr), 0);
    chk("rst_wdata", arr_wdata, 0);
    chk("rst_spin", 32'(spin_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("cmd_ready", 32'(cmd_ready), 1);
    axi_rst = 1'b0;
    @(negedge clk);

    // 1: weight write with clamp
    wr(16'h1014, 32'd20);
    chk("w5_wready", 32'(arr_wready), 1);
    chk("w5_addr", 32'(arr_wr_addr), 5);
    chk("w5_data", arr_wdata, 14);
    @(negedge clk);
    chk("w5_pulse_end", 32'(arr_wready), 0);
    chk("w5_addr_hold", 32'(arr_wr_addr), 5);
    wr(16'h10FC, 32'd3);
    chk("w63_addr", 32'(arr_wr_addr), 63);
    chk("w63_data", arr_wdata, 3);
    wr(16'h1100, 32'd7);
    chk("oob_wready", 32'(arr_wready), 0);
    chk("oob_addr", 32'(arr_wr_addr), 63);
    chk("oob_err", 32'(err), 0);

    // 2: L=10 run, cycle-exact rstn/busy/done
    wr(16'h0004, 32'd10);
    wr(16'h0000, 32'h1);
    for (int c = 1; c <= 17; c++) begin
      chk($sformatf("r10_rstn_c%0d", c), 32'(ising_rstn), 32'(c >= 5));
      chk($sformatf("r10_busy_c%0d", c), 32'(busy), 32'(c <= 15));
      chk($sformatf("r10_done_c%0d", c), 32'(done), 32'(c >= 16));
      @(negedge clk);
    end
    chk("r10_spin", 32'(spin_out), 32'hA5);

    // 5: restart from DONE with a new phase pattern
    phase_in = 8'h3C;
    wr(16'h0000, 32'h1);
    chk("re_done_drop", 32'(done), 0);
    chk("re_busy", 32'(busy), 1);
    wait_done(cyc);
    chk("re_latency", 32'(cyc), 16);
    chk("re_spin", 32'(spin_out), 32'h3C);
    wr(16'h0000, 32'h2);
    chk("clr_rstn", 32'(ising_rstn), 0);
    chk("clr_done", 32'(done), 0);
    chk("clr_busy", 32'(busy), 0);

    // 3: ANNEAL_LEN=0 runs as L=1
    phase_in = 8'h5A;
    wr(16'h0004, 32'd0);
    wr(16'h0000, 32'h1);
    wait_done(cyc);
    chk("l0_latency", 32'(cyc), 7);
    chk("l0_spin", 32'(spin_out), 32'h5A);
    wr(16'h0000, 32'h2);

    // 4: dropped write while busy, then start|abort, then clear
    phase_in = 8'hFF;
    wr(16'h0004, 32'd20);
    wr(16'h0000, 32'h1);
    repeat (6) @(negedge clk);
    chk("ab_in_run", 32'(ising_rstn), 1);
    wr(16'h1000, 32'd1);
    chk("busy_wready", 32'(arr_wready), 0);
    chk("busy_err", 32'(err), 1);
    chk("busy_addr", 32'(arr_wr_addr), 63);
    wr(16'h0000, 32'h5);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_rstn", 32'(ising_rstn), 0);
    chk("ab_done", 32'(done), 0);
    chk("ab_spin", 32'(spin_out), 32'h5A);
    chk("ab_err_kept", 32'(err), 1);
    @(negedge clk);
    chk("ab_stays_idle", 32'(busy), 0);
    wr(16'h0000, 32'h2);
    chk("clr_err", 32'(err), 0);

    // 6: async reset mid-run, then default length
    wr(16'h0000, 32'h1);
    repeat (7) @(negedge clk);
    wr(16'h1004, 32'd2);
    chk("pre_rst_err", 32'(err), 1);
    #2 axi_rst = 1'b1;
    #1;
    chk("ar_rstn", 32'(ising_rstn), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_spin", 32'(spin_out), 0);
    chk("ar_err", 32'(err), 0);
    @(negedge clk);
    axi_rst = 1'b0;
    @(negedge clk);
    wr(16'h0000, 32'h1);
    wait_done(cyc);
    chk("def_len_latency", 32'(cyc), 1006);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
